// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults and sizing helpers for the VGA timing generator.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_HS_POL   = 0;
  localparam int DEF_VS_POL   = 0;
  localparam int DEF_COLOR_W  = 1;
  localparam int DEF_CNT_W    = 10;

  function automatic int calc_h_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int calc_v_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Colour bus is three equal channels packed as {R, G, B}.
  function automatic int rgb_width(input int color_w);
    return 3 * color_w;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one display axis (horizontal or vertical).
module vga_axis_counter #(
  parameter int TOTAL = 800,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap_out
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Qualified with en so the next axis can chain on it directly.
  assign wrap_out = en && (cnt_q == LAST);
  assign count    = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel enable, sync polarity and registered colour.
// Define VGA_TEST_PATTERN_EN to replace rgb_in with eight built-in vertical colour bars.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = DEF_HS_POL,
  parameter int VS_POL   = DEF_VS_POL,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pix_en,
  input  logic [rgb_width(COLOR_W)-1:0]  rgb_in,
  output logic                           hsync,
  output logic                           vsync,
  output logic                           video_on,
  output logic [CNT_W-1:0]               pixel_x,
  output logic [CNT_W-1:0]               pixel_y,
  output logic                           line_start,
  output logic                           frame_start,
  output logic [rgb_width(COLOR_W)-1:0]  rgb
);

  localparam int H_TOTAL   = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL   = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam int RGB_W     = rgb_width(COLOR_W);

  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ON      = (HS_POL != 0);
  localparam logic             VS_ON      = (VS_POL != 0);

  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must all be non-zero");
  end

  if ((longint'(1) << CNT_W) < longint'(MAX_TOTAL)) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W=%0d cannot hold a count of %0d", CNT_W, MAX_TOTAL);
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_en;
  logic             v_wrap_unused;

  assign v_en = pix_en && h_wrap;

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .W     (CNT_W)
  ) u_h_axis (
    .clk      (clk),
    .reset    (reset),
    .en       (pix_en),
    .count    (h_cnt),
    .wrap_out (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .W     (CNT_W)
  ) u_v_axis (
    .clk      (clk),
    .reset    (reset),
    .en       (v_en),
    .count    (v_cnt),
    .wrap_out (v_wrap_unused)
  );

  logic [RGB_W-1:0] colour_src;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]       bar_idx;
  logic [2:0]       bar_val;
  logic [RGB_W-1:0] pattern;
  logic             rgb_in_unused;

  assign rgb_in_unused = ^rgb_in;

  // Bar index (h*8)/H_ACTIVE as a count of constant thresholds crossed.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (int'(h_cnt) * 8 >= k * H_ACTIVE) begin
        bar_idx = bar_idx + 3'd1;
      end
    end
    bar_val = 3'd7 - bar_idx;
    pattern = {{COLOR_W{bar_val[2]}}, {COLOR_W{bar_val[1]}}, {COLOR_W{bar_val[0]}}};
  end

  assign colour_src = pattern;
`else
  assign colour_src = rgb_in;
`endif

  logic             video_d;
  logic             hsync_d;
  logic             vsync_d;
  logic             line_d;
  logic             frame_d;
  logic [RGB_W-1:0] rgb_d;

  always_comb begin
    video_d = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hsync_d = ((h_cnt >= HS_START_C) && (h_cnt < HS_END_C)) ? HS_ON : ~HS_ON;
    vsync_d = ((v_cnt >= VS_START_C) && (v_cnt < VS_END_C)) ? VS_ON : ~VS_ON;
    line_d  = (h_cnt == '0);
    frame_d = (h_cnt == '0) && (v_cnt == '0);
    rgb_d   = video_d ? colour_src : '0;
  end

  logic [CNT_W-1:0] pixel_x_q;
  logic [CNT_W-1:0] pixel_y_q;
  logic             video_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             line_q;
  logic             frame_q;
  logic [RGB_W-1:0] rgb_q;

  // Strobes clear on idle edges so each one lasts a single enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_x_q <= '0;
      pixel_y_q <= '0;
      video_q   <= 1'b0;
      hsync_q   <= ~HS_ON;
      vsync_q   <= ~VS_ON;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      rgb_q     <= '0;
    end else if (pix_en) begin
      pixel_x_q <= h_cnt;
      pixel_y_q <= v_cnt;
      video_q   <= video_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      rgb_q     <= rgb_d;
    end else begin
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
    end
  end

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign video_on    = video_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a small video mode; honours VGA_TEST_PATTERN_EN.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 4;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 3;
  localparam int HSP = 0, VSP = 1, CW = 2, CNTW = 5;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int RW = 3 * CW;
  localparam bit HS_ON = (HSP != 0);
  localparam bit VS_ON = (VSP != 0);

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [RW-1:0] CA = 6'b111111;
  localparam logic [RW-1:0] CB = 6'b111100;
`else
  localparam logic [RW-1:0] CA = 6'b101101;
  localparam logic [RW-1:0] CB = 6'b000000;
`endif

  typedef struct packed {
    logic [CNTW-1:0] x;
    logic [CNTW-1:0] y;
    logic            vid;
    logic            hs;
    logic            vs;
    logic            ls;
    logic            fs;
    logic [RW-1:0]   rgb;
  } outs_t;

  typedef struct {
    bit    r;
    bit    e;
    int    rin;
    outs_t exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            pix_en;
  logic [RW-1:0]   rgb_in;
  logic            hsync, vsync, video_on, line_start, frame_start;
  logic [CNTW-1:0] pixel_x, pixel_y;
  logic [RW-1:0]   rgb;

  int    errors = 0;
  int    checks = 0;
  int    mx = 0, my = 0;
  outs_t mo;
  int    maxX = 0, maxY = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .COLOR_W(CW), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .rgb_in(rgb_in),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start), .rgb(rgb)
  );

  function automatic logic [RW-1:0] colourFor(input int x, input int rin);
`ifdef VGA_TEST_PATTERN_EN
    int v;
    logic [CW-1:0] r, g, b;
    v = 7 - (x * 8) / HA;
    r = ((v & 4) != 0) ? '1 : '0;
    g = ((v & 2) != 0) ? '1 : '0;
    b = ((v & 1) != 0) ? '1 : '0;
    return {r, g, b};
`else
    if (x < 0) return '0;
    return RW'(rin);
`endif
  endfunction

  function automatic outs_t resetOuts();
    outs_t o;
    o = '0;
    o.hs = !HS_ON;
    o.vs = !VS_ON;
    return o;
  endfunction

  // Output tuple a pixel at (x, y) should produce, straight from the mode's rules.
  function automatic outs_t decode(input int x, input int y, input int rin);
    outs_t o;
    o.x   = CNTW'(x);
    o.y   = CNTW'(y);
    o.vid = (x < HA) && (y < VA);
    o.hs  = (x >= HA + HFP && x < HA + HFP + HSW) ? HS_ON : !HS_ON;
    o.vs  = (y >= VA + VFP && y < VA + VFP + VSW) ? VS_ON : !VS_ON;
    o.ls  = (x == 0);
    o.fs  = (x == 0) && (y == 0);
    o.rgb = o.vid ? colourFor(x, rin) : '0;
    return o;
  endfunction

  task automatic applyStimulus(input bit r, input bit e, input int rin);
    reset  = r;
    pix_en = e;
    rgb_in = RW'(rin);
    @(posedge clk);
    if (r) begin
      mx = 0;
      my = 0;
      mo = resetOuts();
    end else if (e) begin
      mo = decode(mx, my, rin);
      mx = mx + 1;
      if (mx == HT) begin
        mx = 0;
        my = (my + 1) % VT;
      end
    end else begin
      mo.ls = 1'b0;
      mo.fs = 1'b0;
    end
    #1;
  endtask

  task automatic checkOutput(input string name, input outs_t e);
    outs_t a;
    a = '{pixel_x, pixel_y, video_on, hsync, vsync, line_start, frame_start, rgb};
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s: got x=%0d y=%0d vid=%0b hs=%0b vs=%0b ls=%0b fs=%0b rgb=%0h, expected x=%0d y=%0d vid=%0b hs=%0b vs=%0b ls=%0b fs=%0b rgb=%0h",
               name, a.x, a.y, a.vid, a.hs, a.vs, a.ls, a.fs, a.rgb,
               e.x, e.y, e.vid, e.hs, e.vs, e.ls, e.fs, e.rgb);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Continuous enabled frames with sync-width, period and wrap bookkeeping.
  task automatic runFrames(input int cycles);
    int  lastFs = -1, hsCnt = 0, hsFirst = -1, vsLines = 0, vsFirst = -1;
    int  px, py, prevX = -1, prevY = -1;
    bit  lineOpen = 0, frameOpen = 0;
    for (int c = 0; c < cycles; c++) begin
      applyStimulus(0, 1, int'($urandom_range(0, (1 << RW) - 1)));
      checkOutput("frame_run", mo);
      px = int'(pixel_x);
      py = int'(pixel_y);
      if (px > maxX) maxX = px;
      if (py > maxY) maxY = py;
      if (prevX == HT - 1 && prevY == VT - 1) begin
        checkInt("wrap_x", px, 0);
        checkInt("wrap_y", py, 0);
        checkInt("wrap_frame_start", int'(frame_start), 1);
      end
      if (line_start) begin
        if (lineOpen) begin
          checkInt("hsync_width", hsCnt, HSW);
          checkInt("hsync_first_x", hsFirst, HA + HFP);
        end
        lineOpen = 1;
        hsCnt    = 0;
        hsFirst  = -1;
      end
      if (frame_start) begin
        if (frameOpen) begin
          checkInt("vsync_lines", vsLines, VSW);
          checkInt("vsync_first_y", vsFirst, VA + VFP);
        end
        if (lastFs >= 0) checkInt("frame_period", c - lastFs, HT * VT);
        lastFs    = c;
        frameOpen = 1;
        vsLines   = 0;
        vsFirst   = -1;
      end
      if (line_start && vsync == VS_ON) begin
        if (vsLines == 0) vsFirst = py;
        vsLines++;
      end
      if (hsync == HS_ON) begin
        if (hsCnt == 0) hsFirst = px;
        hsCnt++;
      end
      if (px == HA - 1 && py < VA) checkInt("last_active_video", int'(video_on), 1);
      if (px == HA) checkInt("first_blank_video", int'(video_on), 0);
      prevX = px;
      prevY = py;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t  tbl[10];
    outs_t first;
    bit    found;

    first = '{x: '0, y: '0, vid: 1'b1, hs: 1'b1, vs: 1'b0, ls: 1'b1, fs: 1'b1, rgb: CA};
    for (int i = 0; i < 5; i++) tbl[i] = '{1, 1, 45, '{'0, '0, 0, 1, 0, 0, 0, '0}};
    tbl[5] = '{0, 1, 45, first};
    tbl[6] = '{0, 0, 45, '{5'd0, 5'd0, 1, 1, 0, 0, 0, CA}};
    tbl[7] = '{0, 1, 45, '{5'd1, 5'd0, 1, 1, 0, 0, 0, CA}};
    tbl[8] = '{0, 0, 45, '{5'd1, 5'd0, 1, 1, 0, 0, 0, CA}};
    tbl[9] = '{0, 1, 0,  '{5'd2, 5'd0, 1, 1, 0, 0, 0, CB}};

    reset  = 1'b1;
    pix_en = 1'b0;
    rgb_in = '0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].r, tbl[i].e, tbl[i].rin);
      checkOutput($sformatf("vector_%0d", i), tbl[i].exp);
      checkOutput("vector_model", mo);
    end

    runFrames(3 * HT * VT);

    for (int c = 0; c < 3000; c++) begin
      applyStimulus(0, bit'($urandom_range(0, 1)), int'($urandom_range(0, (1 << RW) - 1)));
      checkOutput("random_enable", mo);
      if (int'(pixel_x) > maxX) maxX = int'(pixel_x);
      if (int'(pixel_y) > maxY) maxY = int'(pixel_y);
    end

    found = 0;
    for (int c = 0; c < 2 * HT * VT; c++) begin
      if (int'(mo.x) == HA + HFP + 2 && int'(mo.y) == VA + VFP + 1) begin
        found = 1;
        break;
      end
      applyStimulus(0, 1, 45);
      checkOutput("seek_reset_point", mo);
    end
    checkInt("reached_reset_point", int'(found), 1);
    checkInt("in_sync_before_reset", int'(hsync == HS_ON && vsync == VS_ON), 1);
    applyStimulus(1, 1, 45);
    checkOutput("mid_frame_reset", resetOuts());
    applyStimulus(0, 1, 45);
    checkOutput("restart_first_pixel", first);
    for (int c = 0; c < 40; c++) begin
      applyStimulus(0, 1, 45);
      checkOutput("after_reset", mo);
      if (int'(pixel_x) < HA + HFP) checkInt("no_stray_hsync", int'(hsync), int'(!HS_ON));
    end

    checkInt("max_pixel_x", maxX, HT - 1);
    checkInt("max_pixel_y", maxY, VT - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
